// File: rtl/bus_req_arbiter.sv
// -----------------------------------------------------------------------------
// bus_req_arbiter
//
// Shares one request/acknowledge bus between NREQ requesters. Arbitration is
// round-robin and only one transaction is outstanding at a time. A level
// request on rq_req[i] becomes a single-cycle bus_req pulse carrying
// rq_data[i]. The single-cycle bus_ack is routed back as rq_ack[i]. A
// transaction that sees no bus_ack within TIMEOUT wait cycles ends with
// rq_err[i] instead.
//
// Parameters
//   NREQ     number of requesters, 2..16
//   DW       bus_data width
//   TIMEOUT  wait cycles allowed before rq_err, 1..255; 0 disables the timeout
//
// Ports
//   clk        single clock, all logic on posedge
//   reset      synchronous, active-high
//   rq_req     per-requester level request, held until rq_ack/rq_err
//   rq_data    requester i data at [i*DW +: DW]
//   rq_ack     one-hot single-cycle pulse: transaction acknowledged
//   rq_err     one-hot single-cycle pulse: transaction timed out
//   bus_req    single-cycle request pulse to the bus
//   bus_data   data of the current (or last) transaction
//   bus_ack    single-cycle acknowledge from the bus
//   busy       high while a transaction is outstanding
//   cur_id     index of the requester owning the bus (valid when busy)
//   stray_ack  single-cycle pulse: bus_ack seen while idle
// -----------------------------------------------------------------------------
module bus_req_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    rq_req,
   input  logic [NREQ*DW-1:0] rq_data,
   output logic [NREQ-1:0]    rq_ack,
   output logic [NREQ-1:0]    rq_err,
   output logic               bus_req,
   output logic [DW-1:0]      bus_data,
   input  logic               bus_ack,
   output logic               busy,
   output logic [3:0]         cur_id,
   output logic               stray_ack
);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t          state_q,     state_d;
   logic [3:0]      ptr_q,       ptr_d;
   logic [3:0]      cur_id_q,    cur_id_d;
   logic [7:0]      cnt_q,       cnt_d;
   logic [DW-1:0]   bus_data_q,  bus_data_d;
   logic            bus_req_q,   bus_req_d;
   logic            stray_q,     stray_d;
   logic [NREQ-1:0] rq_ack_q,    rq_ack_d;
   logic [NREQ-1:0] rq_err_q,    rq_err_d;

   logic [15:0]     elig_ext;
   logic            found;
   logic [3:0]      winner;
   logic [4:0]      rr_idx;
   logic [DW-1:0]   win_data;
   logic [NREQ-1:0] cur_onehot;
   logic            timeout_hit;

   // Round-robin search: first eligible requester at or after ptr_q.
   // The requester whose rq_ack/rq_err is on the outputs this cycle is masked
   // so a held request is not immediately re-granted.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      elig_ext           = '0;
      elig_ext[NREQ-1:0] = rq_req & ~rq_ack_q & ~rq_err_q;
      found              = 1'b0;
      winner             = '0;
      rr_idx             = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_idx = {1'b0, ptr_q} + 5'(k);
         if (rr_idx >= 5'(NREQ)) begin
            rr_idx = rr_idx - 5'(NREQ);
         end
         if (!found && elig_ext[rr_idx[3:0]]) begin
            found  = 1'b1;
            winner = rr_idx[3:0];
         end
      end
   end

   // Data of the winner and one-hot of the current owner.
   always_comb begin
      win_data   = '0;
      cur_onehot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == 4'(i)) begin
            win_data = rq_data[i*DW +: DW];
         end
         cur_onehot[i] = (cur_id_q == 4'(i));
      end
   end

   // cnt_q is 0 in the bus_req cycle, so TIMEOUT wait cycles end at TIMEOUT-1.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cur_id_d   = cur_id_q;
      cnt_d      = cnt_q;
      bus_data_d = bus_data_q;
      bus_req_d  = 1'b0;
      stray_d    = 1'b0;
      rq_ack_d   = '0;
      rq_err_d   = '0;

      case (state_q)
         ST_IDLE: begin
            stray_d = bus_ack;
            if (found) begin
               state_d    = ST_WAIT;
               cur_id_d   = winner;
               bus_data_d = win_data;
               ptr_d      = (winner == 4'(NREQ - 1)) ? 4'd0 : winner + 4'd1;
               cnt_d      = '0;
               bus_req_d  = 1'b1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // Ack takes priority over a timeout expiring in the same cycle.
            if (bus_ack) begin
               rq_ack_d = cur_onehot;
               state_d  = ST_IDLE;
            end else if (timeout_hit) begin
               rq_err_d = cur_onehot;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         // NOTE: bus_data is an ordinary register, not storage, so it is reset with the rest.
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cur_id_q   <= '0;
         cnt_q      <= '0;
         bus_data_q <= '0;
         bus_req_q  <= 1'b0;
         stray_q    <= 1'b0;
         rq_ack_q   <= '0;
         rq_err_q   <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cur_id_q   <= cur_id_d;
         cnt_q      <= cnt_d;
         bus_data_q <= bus_data_d;
         bus_req_q  <= bus_req_d;
         stray_q    <= stray_d;
         rq_ack_q   <= rq_ack_d;
         rq_err_q   <= rq_err_d;
      end
   end

   assign rq_ack    = rq_ack_q;
   assign rq_err    = rq_err_q;
   assign bus_req   = bus_req_q;
   assign bus_data  = bus_data_q;
   assign busy      = (state_q == ST_WAIT);
   assign cur_id    = cur_id_q;
   assign stray_ack = stray_q;

endmodule
